// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// uart_rx_cfg: configurable UART receiver with a runtime prescale, three-sample
// majority vote per bit, false-start rejection, optional parity, 1/2 stop bits
// and framing/parity/break reporting.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_in               asynchronous serial line (idle high)
//   par_en, par_typ     parity present / parity type (0 even, 1 odd)
//   two_stop            two stop bits expected
//   prescale            clocks per bit (8..63)
//   p_data              last received data word
//   data_valid          one-cycle pulse for an error-free frame
//   par_err, stp_err    status of the last completed frame
//   brk_det             one-cycle pulse for an all-zero (break) frame
//   busy                frame in progress
module uart_rx_cfg #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  two_stop,
    input  logic [5:0]            prescale,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  brk_det,
    output logic                  busy
);

    localparam int unsigned TW  = 6;
    localparam int unsigned BCW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_WAIT_HIGH
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [TW-1:0]          presc_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   two_stop_q;

    logic [TW-1:0]          tick_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [2:0]             samp;
    logic                   perr_q;
    logic                   serr_q;
    logic                   zero_q;

    logic [TW-1:0]          mid_c;
    logic                   last_tick_c;
    logic                   in_bit_c;
    logic                   vote_c;
    logic                   frame_done_c;
    logic                   serr_fin_c;
    logic                   brk_fin_c;

    // Input synchroniser, preset to idle-high
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    assign rx_s        = sync_q[SYNC_STAGES-1];
    assign mid_c       = {1'b0, presc_q[TW-1:1]};
    assign last_tick_c = (tick_cnt == presc_q - TW'(1));
    assign in_bit_c    = (state == S_START) || (state == S_DATA) || (state == S_PARITY) ||
                         (state == S_STOP1) || (state == S_STOP2);
    assign vote_c      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    // Final stop verdicts include the bit being evaluated this cycle
    assign serr_fin_c  = serr_q | ~vote_c;
    assign brk_fin_c   = zero_q & ~vote_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n      = state;
        frame_done_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (last_tick_c) state_n = vote_c ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (last_tick_c && (bit_cnt == BCW'(DATA_WIDTH - 1)))
                    state_n = par_en_q ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (last_tick_c) state_n = S_STOP1;
            end
            S_STOP1: begin
                if (last_tick_c) begin
                    if (two_stop_q) begin
                        state_n = S_STOP2;
                    end else begin
                        frame_done_c = 1'b1;
                        state_n      = serr_fin_c ? S_WAIT_HIGH : S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (last_tick_c) begin
                    frame_done_c = 1'b1;
                    state_n      = serr_fin_c ? S_WAIT_HIGH : S_IDLE;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: tick/bit counters, voting samples, shift register, status
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            samp       <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            zero_q     <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk_det    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            brk_det    <= 1'b0;
            busy       <= (state_n != S_IDLE);

            // The start-detect cycle in IDLE is tick 0 of the start bit
            if (state == S_IDLE) begin
                tick_cnt <= rx_s ? TW'(0) : TW'(1);
                if (!rx_s) begin
                    presc_q    <= prescale;
                    par_en_q   <= par_en;
                    par_typ_q  <= par_typ;
                    two_stop_q <= two_stop;
                    bit_cnt    <= '0;
                    perr_q     <= 1'b0;
                    serr_q     <= 1'b0;
                    zero_q     <= 1'b1;
                end
            end else if (in_bit_c) begin
                tick_cnt <= last_tick_c ? TW'(0) : tick_cnt + TW'(1);
            end else begin
                tick_cnt <= '0;
            end

            if (in_bit_c) begin
                if (tick_cnt == mid_c - TW'(1)) samp[0] <= rx_s;
                if (tick_cnt == mid_c)          samp[1] <= rx_s;
                if (tick_cnt == mid_c + TW'(1)) samp[2] <= rx_s;
            end

            if (last_tick_c) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {vote_c, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (vote_c) zero_q <= 1'b0;
                    end
                    S_PARITY: begin
                        if (vote_c != ((^shreg) ^ par_typ_q)) perr_q <= 1'b1;
                        if (vote_c) zero_q <= 1'b0;
                    end
                    S_STOP1, S_STOP2: begin
                        if (!vote_c) serr_q <= 1'b1;
                        if (vote_c)  zero_q <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (frame_done_c) begin
                p_data     <= shreg;
                par_err    <= perr_q;
                stp_err    <= serr_fin_c;
                data_valid <= ~perr_q & ~serr_fin_c;
                brk_det    <= brk_fin_c;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_cfg: an 8-bit and a 9-bit instance share clock,
// reset and configuration; each has its own serial line.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx8, rx9;
    logic       par_en, par_typ, two_stop;
    logic [5:0] prescale;

    logic [7:0] p_data8;
    logic       dv8, perr8, serr8, brk8, busy8;
    logic [8:0] p_data9;
    logic       dv9, perr9, serr9, brk9, busy9;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    int dv8_cnt = 0, brk8_cnt = 0, dv9_cnt = 0, brk9_cnt = 0;
    int illegal_cnt = 0;
    logic [8:0] rec9 [0:3];

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_rx8 (
        .clk(clk), .rst(rst), .rx_in(rx8), .par_en(par_en), .par_typ(par_typ),
        .two_stop(two_stop), .prescale(prescale), .p_data(p_data8),
        .data_valid(dv8), .par_err(perr8), .stp_err(serr8), .brk_det(brk8), .busy(busy8)
    );

    uart_rx_cfg #(.DATA_WIDTH(9), .SYNC_STAGES(2)) u_rx9 (
        .clk(clk), .rst(rst), .rx_in(rx9), .par_en(par_en), .par_typ(par_typ),
        .two_stop(two_stop), .prescale(prescale), .p_data(p_data9),
        .data_valid(dv9), .par_err(perr9), .stp_err(serr9), .brk_det(brk9), .busy(busy9)
    );

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (dv8)  dv8_cnt++;
        if (brk8) brk8_cnt++;
        if (brk9) brk9_cnt++;
        if (dv9) begin
            if (dv9_cnt < 4) rec9[dv9_cnt] = p_data9;
            dv9_cnt++;
        end
        if (!rst && prescale < 6'd8) illegal_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input bit sel, input logic v, input int presc);
        if (sel) rx9 = v;
        else     rx8 = v;
        repeat (presc) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input int presc, input int nbits,
                              input logic [8:0] data, input bit par_on, input logic par_bit,
                              input logic stop1, input bit stop2_on, input logic stop2);
        send_bit(sel, 1'b0, presc);
        for (int i = 0; i < nbits; i++) send_bit(sel, data[i], presc);
        if (par_on)   send_bit(sel, par_bit, presc);
        send_bit(sel, stop1, presc);
        if (stop2_on) send_bit(sel, stop2, presc);
    endtask

    int dv_s, brk_s, busy_low, waited;

    initial begin
        for (int i = 0; i < 4; i++) rec9[i] = '0;
        rst = 1'b1; rx8 = 1'b1; rx9 = 1'b1;
        par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b0; prescale = 6'd8;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_p_data8", 32'(p_data8), 32'h0);
        check("rst_busy8",   32'(busy8),   32'h0);
        check("rst_flags8",  32'({perr8, serr8, dv8, brk8}), 32'h0);
        check("rst_p_data9", 32'(p_data9), 32'h0);
        repeat (4) @(negedge clk);

        // 8N1, prescale 8, 0xA5
        dv_s = dv8_cnt; brk_s = brk8_cnt;
        send_frame(0, 8, 8, 9'h0A5, 0, 0, 1, 0, 0);
        repeat (5) @(negedge clk);
        check("a5_dv_pulses", 32'(dv8_cnt - dv_s), 32'd1);
        check("a5_p_data",    32'(p_data8), 32'hA5);
        check("a5_par_err",   32'(perr8), 32'h0);
        check("a5_stp_err",   32'(serr8), 32'h0);
        check("a5_brk",       32'(brk8_cnt - brk_s), 32'd0);
        check("a5_busy_idle", 32'(busy8), 32'h0);

        // 8O1, prescale 16, 0x3C with correct parity 1
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
        repeat (4) @(negedge clk);
        dv_s = dv8_cnt;
        send_frame(0, 16, 8, 9'h03C, 1, 1, 1, 0, 0);
        repeat (5) @(negedge clk);
        check("odd_ok_dv",      32'(dv8_cnt - dv_s), 32'd1);
        check("odd_ok_par_err", 32'(perr8), 32'h0);
        check("odd_ok_p_data",  32'(p_data8), 32'h3C);

        // Same frame with wrong parity bit 0
        repeat (4) @(negedge clk);
        dv_s = dv8_cnt;
        send_frame(0, 16, 8, 9'h03C, 1, 0, 1, 0, 0);
        repeat (5) @(negedge clk);
        check("odd_bad_dv",      32'(dv8_cnt - dv_s), 32'd0);
        check("odd_bad_par_err", 32'(perr8), 32'h1);
        check("odd_bad_p_data",  32'(p_data8), 32'h3C);
        check("odd_bad_stp_err", 32'(serr8), 32'h0);

        // 8N2, prescale 32, second stop bit 0, then line held low
        prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b1;
        repeat (4) @(negedge clk);
        dv_s = dv8_cnt;
        send_frame(0, 32, 8, 9'h05A, 0, 0, 1, 1, 0);
        repeat (5) @(negedge clk);
        check("stop2_stp_err", 32'(serr8), 32'h1);
        check("stop2_dv",      32'(dv8_cnt - dv_s), 32'd0);
        check("stop2_par_err", 32'(perr8), 32'h0);
        check("stop2_p_data",  32'(p_data8), 32'h5A);
        // Config change while waiting must have no effect
        two_stop = 1'b0;
        busy_low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy8) busy_low++;
        end
        check("wait_high_busy_low_cycles", 32'(busy_low), 32'd0);
        check("wait_high_no_frame",        32'(dv8_cnt - dv_s), 32'd0);
        rx8 = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_high_release_busy", 32'(busy8), 32'h0);
        check("wait_high_release_dv",   32'(dv8_cnt - dv_s), 32'd0);

        // False start: 3 low clocks at prescale 16
        prescale = 6'd16;
        repeat (4) @(negedge clk);
        dv_s = dv8_cnt;
        rx8 = 1'b0;
        repeat (3) @(negedge clk);
        check("false_start_busy_set", 32'(busy8), 32'h1);
        rx8 = 1'b1;
        waited = 0;
        while (busy8 && waited < 16 + 2 + 2) begin
            @(negedge clk);
            waited++;
        end
        check("false_start_busy_clear", 32'(busy8), 32'h0);
        repeat (4) @(negedge clk);
        check("false_start_no_dv", 32'(dv8_cnt - dv_s), 32'd0);

        // Single-clock glitch at mid of data bit 3 of frame 0x00
        dv_s = dv8_cnt;
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0, 16);
        rx8 = 1'b0;
        repeat (8) @(negedge clk);
        rx8 = 1'b1;
        @(negedge clk);
        rx8 = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0, 16);
        send_bit(0, 1'b1, 16);
        repeat (5) @(negedge clk);
        check("glitch_dv",     32'(dv8_cnt - dv_s), 32'd1);
        check("glitch_p_data", 32'(p_data8), 32'h00);

        // Break: 12 bit times low, 8E1, prescale 8
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; two_stop = 1'b0;
        repeat (4) @(negedge clk);
        dv_s = dv8_cnt; brk_s = brk8_cnt;
        rx8 = 1'b0;
        repeat (12 * 8) @(negedge clk);
        check("brk_pulses",  32'(brk8_cnt - brk_s), 32'd1);
        check("brk_stp_err", 32'(serr8), 32'h1);
        check("brk_par_err", 32'(perr8), 32'h0);
        check("brk_dv",      32'(dv8_cnt - dv_s), 32'd0);
        check("brk_busy_wait_high", 32'(busy8), 32'h1);
        rx8 = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_busy_idle", 32'(busy8), 32'h0);
        check("brk_single_pulse", 32'(brk8_cnt - brk_s), 32'd1);

        // 9-bit instance: back-to-back 0x1FF, 0x100 at prescale 8, no parity
        par_en = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(1, 8, 9, 9'h1FF, 0, 0, 1, 0, 0);
        send_frame(1, 8, 9, 9'h100, 0, 0, 1, 0, 0);
        repeat (5) @(negedge clk);
        check("b2b_count",  32'(dv9_cnt), 32'd2);
        check("b2b_first",  32'(rec9[0]), 32'h1FF);
        check("b2b_second", 32'(rec9[1]), 32'h100);
        check("b2b_brk",    32'(brk9_cnt), 32'd0);

        // Reset in the middle of a third frame
        send_bit(1, 1'b0, 8);
        send_bit(1, 1'b1, 8);
        send_bit(1, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_p_data9", 32'(p_data9), 32'h0);
        check("midrst_busy9",   32'(busy9),   32'h0);
        check("midrst_flags9",  32'({perr9, serr9, dv9, brk9}), 32'h0);
        rst = 1'b0;
        rx9 = 1'b1;
        repeat (24) @(negedge clk);
        check("midrst_no_pulse", 32'(dv9_cnt), 32'd2);
        check("midrst_idle",     32'(busy9), 32'h0);
        send_frame(1, 8, 9, 9'h055, 0, 0, 1, 0, 0);
        repeat (5) @(negedge clk);
        check("post_rst_count",  32'(dv9_cnt), 32'd3);
        check("post_rst_p_data", 32'(p_data9), 32'h055);
        check("post_rst_rec",    32'(rec9[2]), 32'h055);

        check("prescale_legal", 32'(illegal_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver. Oversamples the serial line by a runtime prescale, votes three samples per bit, and rejects false starts. Supports data width 5–9 bits, optional even/odd parity and 1 or 2 stop bits. Reports framing, parity and break conditions, and sits between the RX pad synchroniser and the byte-level protocol logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9), LSB first on the line
SYNC_STAGES, 2, flip-flop stages on rx_in before sampling (legal 2..3)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_in  input  1  asynchronous serial line, idle high
par_en  input  1  1 = parity bit present after data
par_typ  input  1  0 = even parity, 1 = odd parity
two_stop  input  1  1 = two stop bits expected
prescale  input  6  clocks per bit (legal 8..63; 8/16/32 production values)
p_data  output  DATA_WIDTH  last received data word
data_valid  output  1  one-cycle pulse: error-free frame in p_data
par_err  output  1  status of last completed frame: parity mismatch
stp_err  output  1  status of last completed frame: a stop bit sampled 0
brk_det  output  1  one-cycle pulse: break frame received
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: takes effect on the rising clk edge with rst=1. All outputs go to 0, the FSM to IDLE and the counters to 0. The synchroniser flops are set to 1 (idle). Reset mid-frame aborts the frame with no outputs.
- rx_s: rx_in after SYNC_STAGES flops. All decisions below use rx_s.
- Config latch: par_en, par_typ, two_stop and prescale are captured into shadow registers on the IDLE→START transition. Input changes during a frame are ignored.
- tick_cnt: counts 0..prescale-1 within each bit period. mid = prescale>>1.
- Voting: rx_s is sampled at tick_cnt = mid-1, mid and mid+1. The bit value is the majority of the three samples. The bit is evaluated at tick_cnt = prescale-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: rx_s = 0 → START, and this cycle counts as tick 0.
- START: voted bit 1 → IDLE (glitch), no outputs change. Voted bit 0 → DATA.
- DATA: bit_cnt runs 0..DATA_WIDTH-1. Voted bits shift into a shift register LSB first. After the last bit → PARITY if par_en, else STOP1.
- PARITY: expected parity = XOR(data bits) XOR par_typ. A mismatch sets the internal perr flag. Then → STOP1.
- STOP1: voted 0 sets the internal serr flag. Then → STOP2 if two_stop, else frame completion.
- STOP2: same check as STOP1, then frame completion.
- Frame completion happens in the cycle after the final stop bit evaluation:
  - p_data is loaded from the shift register.
  - par_err is set to perr and stp_err to serr; both are held until the next completion or reset.
  - data_valid pulses for 1 cycle iff perr = 0 and serr = 0.
  - brk_det pulses for 1 cycle iff all data bits, the parity bit (if enabled) and every stop bit sampled 0. stp_err is also 1 in that case.
  - If serr = 1 → WAIT_HIGH; else → IDLE.
- WAIT_HIGH: stays until rx_s = 1, then → IDLE. A line held low is never taken as a new start.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after completion must be accepted; no dead cycle beyond the one IDLE cycle is allowed.
- Latency: rx_in start falling edge to data_valid = SYNC_STAGES + prescale×(1 + DATA_WIDTH + par_en + 1 + two_stop) + 1 clocks, ±1 clock of edge alignment.
- Illegal prescale (<8): behaviour is undefined. It is not checked in RTL; a bench assertion covers it.

Test Plan:
- prescale=8, DATA_WIDTH=8, 8N1, byte 0xA5 → p_data=0xA5, one data_valid pulse, par_err=0, stp_err=0, brk_det=0.
- prescale=16, par_en=1, par_typ=1, data 0x3C with parity bit 1 → data_valid pulse, par_err=0. Repeat with parity bit 0 → no data_valid, par_err=1, p_data=0x3C.
- prescale=32, two_stop=1, data 0x5A, second stop bit driven 0 → stp_err=1, no data_valid. After the frame, hold rx low for 100 clocks: busy stays 1 (WAIT_HIGH) and no new frame starts until rx returns high.
- prescale=16: rx low for 3 clocks, then high → no frame; busy returns to 0 within prescale+SYNC_STAGES clocks. Also a single-sample glitch at the mid-bit of data bit 3 of frame 0x00 → p_data=0x00 thanks to the majority vote.
- Break: rx low for 12 bit times with 8E1, then high → brk_det one pulse, stp_err=1, data_valid=0, FSM back to IDLE after rx goes high.
- DATA_WIDTH=9 instance, prescale=8: frames 0x1FF and 0x100 back-to-back with no idle gap → two data_valid pulses, values in order. Assert rst mid-frame of a third frame → outputs 0, no pulse, next clean frame 0x055 received correctly.
